// File: rtl/am4_cpu_if.sv
// Core-side request/response channel of the am4 QBUS sequencer.
// The microcode core is the master; the bus unit (am4_cpu) is the slave.
interface am4_cpu_if;
    logic        req;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        done;
    logic        err;

    modport master (output req, op, addr, wdata, input rdata, done, err);
    modport slave  (input req, op, addr, wdata, output rdata, done, err);
endinterface

// File: rtl/am4_cpu.sv
// am4 (LSI-11/M4 replica) QBUS bus-interface and power/start sequencer.
// Define AM4_DEBUG_IO_EN for a simulation-only trace of every completed bus cycle.
module am4_cpu #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int INIT_CYCLES    = 32,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic        pin_clk,
    input  logic        pin_rst,
    input  logic        pin_dclo_n,
    input  logic        pin_aclo_n,
    input  logic        pin_halt_n,
    input  logic        pin_evnt_n,
    input  logic        pin_virq_n,
    input  logic        pin_rfrq_n,
    input  logic        pin_dmr_n,
    input  logic        pin_sack_n,
    input  logic        pin_rply_n,
    output logic        pin_dmgo_n,
    inout  wire  [15:0] pin_ad_n,
    output logic        pin_sync_n,
    output logic        pin_din_n,
    output logic        pin_dout_n,
    output logic        pin_wtbt_n,
    output logic        pin_iako_n,
    output logic        pin_dref_n,
    output wire         pin_init_n,
    input  logic [1:0]  pin_bsel_n,
    am4_cpu_if.slave    core,
    output logic        halt_req,
    output logic        evnt_req,
    output logic        virq_req,
    output logic        pwr_fail,
    output logic        start,
    output logic [1:0]  start_mode
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + REFRESH_CYCLES + 1);
    localparam int IW = $clog2(INIT_CYCLES + 1);

    localparam logic [1:0] OP_DATI  = 2'b00;
    localparam logic [1:0] OP_DATO  = 2'b01;
    localparam logic [1:0] OP_DATOB = 2'b10;
    localparam logic [1:0] OP_IAK   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_SYNC    = 3'd2,
        ST_DATA    = 3'd3,
        ST_END     = 3'd4,
        ST_DMA_GNT = 3'd5,
        ST_DMA     = 3'd6,
        ST_REFR    = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          sync_q, sync_d;
    logic          din_q, din_d;
    logic          dout_q, dout_d;
    logic          wtbt_q, wtbt_d;
    logic          iako_q, iako_d;
    logic          dref_q, dref_d;
    logic          dmgo_q, dmgo_d;
    logic          ad_oe_q, ad_oe_d;
    logic [15:0]   ad_out_q, ad_out_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    op_q, op_d;
    logic [15:0]   wdata_q, wdata_d;

    logic          init_q;
    logic [IW-1:0] init_cnt_q;
    logic          run_q;
    logic          start_q;
    logic [1:0]    start_mode_q;

    logic [1:0]    halt_sync_q;
    logic [1:0]    evnt_sync_q;
    logic [1:0]    virq_sync_q;
    logic          pwr_fail_q;
    logic          rply_q;

    logic          reset_s;
    logic          accept_s;

    // DCLO acts exactly like reset: everything drops at once, even mid-cycle.
    assign reset_s  = pin_rst | ~pin_dclo_n;
    assign accept_s = run_q & ~init_q;

    // INIT hold-off counter and the one-clock start pulse on release.
    always_ff @(posedge pin_clk) begin
        if (reset_s) begin
            init_q       <= 1'b1;
            init_cnt_q   <= IW'(INIT_CYCLES);
            run_q        <= 1'b0;
            start_q      <= 1'b0;
            start_mode_q <= 2'b00;
        end else begin
            start_q <= 1'b0;
            if (init_q) begin
                if (!pin_aclo_n) begin
                    init_cnt_q <= IW'(INIT_CYCLES);
                end else if (init_cnt_q == IW'(1)) begin
                    init_q       <= 1'b0;
                    run_q        <= 1'b1;
                    start_q      <= 1'b1;
                    start_mode_q <= ~pin_bsel_n;
                end else begin
                    init_cnt_q <= init_cnt_q - IW'(1);
                end
            end else begin
                init_cnt_q <= init_cnt_q;
            end
        end
    end

    // Request synchronizers, power-fail flag and the registered reply line.
    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            halt_sync_q <= 2'b00;
            evnt_sync_q <= 2'b00;
            virq_sync_q <= 2'b00;
            pwr_fail_q  <= 1'b0;
            rply_q      <= 1'b1;
        end else begin
            halt_sync_q <= {halt_sync_q[0], ~pin_halt_n};
            evnt_sync_q <= {evnt_sync_q[0], ~pin_evnt_n};
            virq_sync_q <= {virq_sync_q[0], ~pin_virq_n};
            pwr_fail_q  <= ~pin_aclo_n;
            rply_q      <= pin_rply_n;
        end
    end

    // Bus sequencer state and registered pin/response values.
    always_ff @(posedge pin_clk) begin
        if (reset_s) begin
            state_q  <= ST_IDLE;
            cyc_q    <= CW'(0);
            sync_q   <= 1'b1;
            din_q    <= 1'b1;
            dout_q   <= 1'b1;
            wtbt_q   <= 1'b1;
            iako_q   <= 1'b1;
            dref_q   <= 1'b1;
            dmgo_q   <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= 16'h0000;
            rdata_q  <= 16'h0000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            op_q     <= 2'b00;
            wdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            sync_q   <= sync_d;
            din_q    <= din_d;
            dout_q   <= dout_d;
            wtbt_q   <= wtbt_d;
            iako_q   <= iako_d;
            dref_q   <= dref_d;
            dmgo_q   <= dmgo_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            op_q     <= op_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state and next-pin decode; pins are computed for the coming state.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        sync_d   = sync_q;
        din_d    = din_q;
        dout_d   = dout_q;
        wtbt_d   = wtbt_q;
        iako_d   = iako_q;
        dref_d   = dref_q;
        dmgo_d   = dmgo_q;
        ad_oe_d  = ad_oe_q;
        ad_out_d = ad_out_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        op_d     = op_q;
        wdata_d  = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s && !pin_dmr_n) begin
                    state_d = ST_DMA_GNT;
                    dmgo_d  = 1'b0;
                end else if (accept_s && !pin_rfrq_n) begin
                    state_d = ST_REFR;
                    dref_d  = 1'b0;
                    cyc_d   = CW'(0);
                end else if (accept_s && core.req) begin
                    op_d    = core.op;
                    wdata_d = core.wdata;
                    if (core.op == OP_IAK) begin
                        state_d = ST_DATA;
                        din_d   = 1'b0;
                        iako_d  = 1'b0;
                        ad_oe_d = 1'b0;
                        cyc_d   = CW'(0);
                    end else begin
                        state_d  = ST_ADDR;
                        ad_oe_d  = 1'b1;
                        ad_out_d = ~core.addr;
                        wtbt_d   = (core.op == OP_DATI);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_d = ST_SYNC;
                sync_d  = 1'b0;
            end
            ST_SYNC: begin
                state_d = ST_DATA;
                cyc_d   = CW'(0);
                if (op_q == OP_DATI) begin
                    ad_oe_d = 1'b0;
                    wtbt_d  = 1'b1;
                    din_d   = 1'b0;
                end else begin
                    // Both lanes carry wdata as given; the slave picks the byte from A0.
                    ad_oe_d  = 1'b1;
                    ad_out_d = ~wdata_q;
                    wtbt_d   = (op_q != OP_DATOB);
                    dout_d   = 1'b0;
                end
            end
            ST_DATA: begin
                if (!rply_q) begin
                    state_d = ST_END;
                    din_d   = 1'b1;
                    dout_d  = 1'b1;
                    iako_d  = 1'b1;
                    wtbt_d  = 1'b1;
                    ad_oe_d = 1'b0;
                    if ((op_q == OP_DATI) || (op_q == OP_IAK)) begin
                        rdata_d = ~pin_ad_n;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cyc_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    sync_d  = 1'b1;
                    din_d   = 1'b1;
                    dout_d  = 1'b1;
                    iako_d  = 1'b1;
                    wtbt_d  = 1'b1;
                    ad_oe_d = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_END: begin
                if (rply_q) begin
                    state_d = ST_IDLE;
                    sync_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_END;
                end
            end
            ST_DMA_GNT: begin
                if (!pin_sack_n) begin
                    state_d = ST_DMA;
                    dmgo_d  = 1'b1;
                end else if (pin_dmr_n) begin
                    state_d = ST_IDLE;
                    dmgo_d  = 1'b1;
                end else begin
                    state_d = ST_DMA_GNT;
                end
            end
            ST_DMA: begin
                if (pin_sack_n) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DMA;
                end
            end
            ST_REFR: begin
                if (cyc_q == CW'(REFRESH_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    dref_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                sync_d  = 1'b1;
                din_d   = 1'b1;
                dout_d  = 1'b1;
                wtbt_d  = 1'b1;
                iako_d  = 1'b1;
                dref_d  = 1'b1;
                dmgo_d  = 1'b1;
                ad_oe_d = 1'b0;
            end
        endcase
    end

    assign pin_ad_n   = ad_oe_q ? ad_out_q : 16'bzzzz_zzzz_zzzz_zzzz;
    assign pin_init_n = init_q ? 1'b0 : 1'bz;
    assign pin_sync_n = sync_q;
    assign pin_din_n  = din_q;
    assign pin_dout_n = dout_q;
    assign pin_wtbt_n = wtbt_q;
    assign pin_iako_n = iako_q;
    assign pin_dref_n = dref_q;
    assign pin_dmgo_n = dmgo_q;

    assign core.rdata = rdata_q;
    assign core.done  = done_q;
    assign core.err   = err_q;

    assign halt_req   = halt_sync_q[1];
    assign evnt_req   = evnt_sync_q[1];
    assign virq_req   = virq_sync_q[1];
    assign pwr_fail   = pwr_fail_q;
    assign start      = start_q;
    assign start_mode = start_mode_q;

`ifdef AM4_DEBUG_IO_EN
    // Trace each cycle on the clock it completes; the core still holds addr here.
    always @(posedge pin_clk) begin
        if (!reset_s && done_d) begin
            if (err_d) begin
                $display("Bus timeout @ %06o", core.addr);
            end else if (op_q == OP_IAK) begin
                $display("Read @ Vector");
            end else if (op_q == OP_DATI) begin
                $display("Read @ %06o (%06o)", core.addr, rdata_d);
            end else begin
                $display("Write @ %06o (%06o)", core.addr, wdata_q);
            end
        end
    end
`else
    // Normal builds carry no trace logic.
`endif

endmodule

// File: tb/tb_am4_cpu.sv
// Directed bench for am4_cpu: power-up sequence, bus cycles, timeout, DMA/refresh priority.
module tb_am4_cpu;
    localparam int TMO = 64;
    localparam int INI = 32;
    localparam int REF = 4;

    logic        pin_clk;
    logic        pin_rst;
    logic        pin_dclo_n, pin_aclo_n;
    logic        pin_halt_n, pin_evnt_n, pin_virq_n;
    logic        pin_rfrq_n, pin_dmr_n, pin_sack_n, pin_rply_n;
    logic        pin_dmgo_n;
    tri1  [15:0] pin_ad_n;
    logic        pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_iako_n, pin_dref_n;
    tri1         pin_init_n;
    logic [1:0]  pin_bsel_n;
    logic        halt_req, evnt_req, virq_req, pwr_fail, start;
    logic [1:0]  start_mode;

    am4_cpu_if core_bus();

    am4_cpu #(.TIMEOUT_CYCLES(TMO), .INIT_CYCLES(INI), .REFRESH_CYCLES(REF)) dut (
        .pin_clk(pin_clk), .pin_rst(pin_rst), .pin_dclo_n(pin_dclo_n), .pin_aclo_n(pin_aclo_n),
        .pin_halt_n(pin_halt_n), .pin_evnt_n(pin_evnt_n), .pin_virq_n(pin_virq_n),
        .pin_rfrq_n(pin_rfrq_n), .pin_dmr_n(pin_dmr_n), .pin_sack_n(pin_sack_n),
        .pin_rply_n(pin_rply_n), .pin_dmgo_n(pin_dmgo_n), .pin_ad_n(pin_ad_n),
        .pin_sync_n(pin_sync_n), .pin_din_n(pin_din_n), .pin_dout_n(pin_dout_n),
        .pin_wtbt_n(pin_wtbt_n), .pin_iako_n(pin_iako_n), .pin_dref_n(pin_dref_n),
        .pin_init_n(pin_init_n), .pin_bsel_n(pin_bsel_n), .core(core_bus),
        .halt_req(halt_req), .evnt_req(evnt_req), .virq_req(virq_req),
        .pwr_fail(pwr_fail), .start(start), .start_mode(start_mode)
    );

    initial pin_clk = 1'b0;
    always #5 pin_clk = ~pin_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %06o expected %06o", tag, got, exp);
        end
    endtask

    // Bus slave model: memory at every address except 160000, interrupt vector 000064.
    logic        dev_oe;
    logic [15:0] dev_ad;
    logic [15:0] lat_addr;
    logic [15:0] wr_data;
    assign pin_ad_n = dev_oe ? dev_ad : 16'bzzzz_zzzz_zzzz_zzzz;

    always @(negedge pin_sync_n) lat_addr = ~pin_ad_n;

    initial begin
        dev_oe     = 1'b0;
        dev_ad     = 16'h0000;
        wr_data    = 16'h0000;
        pin_rply_n = 1'b1;
        forever begin
            @(pin_din_n or pin_dout_n or pin_iako_n);
            #2;
            if (!pin_din_n && !pin_iako_n) begin
                if (!pin_virq_n) begin
                    dev_ad = ~16'o000064; dev_oe = 1'b1; pin_rply_n = 1'b0;
                end
            end else if (!pin_din_n) begin
                if (lat_addr != 16'o160000) begin
                    dev_ad = (lat_addr == 16'o001000) ? ~16'o012737 : ~16'o000000;
                    dev_oe = 1'b1; pin_rply_n = 1'b0;
                end
            end else if (!pin_dout_n) begin
                if (lat_addr != 16'o160000) begin
                    wr_data = ~pin_ad_n; pin_rply_n = 1'b0;
                end
            end else begin
                dev_oe = 1'b0; pin_rply_n = 1'b1;
            end
        end
    end

    logic [15:0] ph_addr_ad, ph_sync_ad, ph_data_ad;
    logic        ph_addr_wtbt, ph_data_wtbt;
    logic        sync_seen, dout_seen, iako_seen, done_seen, err_done;
    logic [3:0]  strobes_done;
    int          din_at, done_at;

    // Issue one core request and record what each bus phase looked like.
    task automatic bus_cycle(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
        int n;
        n = 0; din_at = -1; done_at = -1;
        sync_seen = 1'b0; dout_seen = 1'b0; iako_seen = 1'b0; done_seen = 1'b0; err_done = 1'b0;
        ph_addr_ad = 16'h0000; ph_sync_ad = 16'h0000; ph_data_ad = 16'h0000;
        ph_addr_wtbt = 1'b1; ph_data_wtbt = 1'b1; strobes_done = 4'h0;
        core_bus.req = 1'b1; core_bus.op = op; core_bus.addr = a; core_bus.wdata = d;
        while (!done_seen && n < 200) begin
            @(posedge pin_clk); #1; n = n + 1;
            if (n == 1) begin ph_addr_ad = pin_ad_n; ph_addr_wtbt = pin_wtbt_n; end
            if (!pin_sync_n && !sync_seen) begin sync_seen = 1'b1; ph_sync_ad = pin_ad_n; end
            if (!pin_din_n && din_at < 0) din_at = n;
            if (!pin_dout_n && !dout_seen) begin
                dout_seen = 1'b1; ph_data_ad = pin_ad_n; ph_data_wtbt = pin_wtbt_n;
            end
            if (!pin_iako_n) iako_seen = 1'b1;
            if (core_bus.done) begin
                done_seen = 1'b1; done_at = n; err_done = core_bus.err;
                strobes_done = {pin_sync_n, pin_din_n, pin_dout_n, pin_iako_n};
            end
        end
        core_bus.req = 1'b0;
        check("done_seen", 16'(done_seen), 16'd1);
        @(posedge pin_clk); #1;
        check("done_pulse", 16'(core_bus.done), 16'd0);
    endtask

    int n, t_dmgo, t_sack_rel, t_dref, t_sync, dref_len;
    logic dma_drive, got_start, any_done;

    initial begin
        pin_rst = 1'b1; pin_dclo_n = 1'b1; pin_aclo_n = 1'b0;
        pin_halt_n = 1'b1; pin_evnt_n = 1'b1; pin_virq_n = 1'b1;
        pin_rfrq_n = 1'b1; pin_dmr_n = 1'b1; pin_sack_n = 1'b1;
        pin_bsel_n = 2'b11;
        core_bus.req = 1'b0; core_bus.op = 2'b00; core_bus.addr = 16'h0000; core_bus.wdata = 16'h0000;

        repeat (24) @(posedge pin_clk);
        #1;
        check("rst_init", 16'(pin_init_n), 16'd0);
        check("rst_strobes", 16'({pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_iako_n}), 16'h1f);
        check("rst_dmgo_dref", 16'({pin_dmgo_n, pin_dref_n}), 16'h3);
        check("rst_ad_z", pin_ad_n, 16'hffff);
        check("rst_rdata", core_bus.rdata, 16'h0000);
        check("rst_done_err_start", 16'({core_bus.done, core_bus.err, start}), 16'h0);
        pin_rst = 1'b0;

        repeat (66) @(posedge pin_clk);
        #1;
        check("pwr_fail_on", 16'(pwr_fail), 16'd1);
        check("init_held_aclo", 16'(pin_init_n), 16'd0);
        pin_aclo_n = 1'b1;
        repeat (INI - 1) @(posedge pin_clk);
        #1;
        check("init_still_low", 16'(pin_init_n), 16'd0);
        check("no_early_start", 16'(start), 16'd0);
        @(posedge pin_clk); #1;
        check("init_released", 16'(pin_init_n), 16'd1);
        check("start_pulse", 16'(start), 16'd1);
        check("start_mode", 16'(start_mode), 16'd0);
        @(posedge pin_clk); #1;
        check("start_one_clk", 16'(start), 16'd0);
        check("pwr_fail_off", 16'(pwr_fail), 16'd0);

        pin_virq_n = 1'b0;
        @(posedge pin_clk); #1;
        check("virq_sync_1", 16'(virq_req), 16'd0);
        @(posedge pin_clk); #1;
        check("virq_sync_2", 16'(virq_req), 16'd1);

        bus_cycle(2'b00, 16'o001000, 16'h0000);
        check("dati_addr_wtbt", 16'(ph_addr_wtbt), 16'd1);
        check("dati_sync_ad", ph_sync_ad, ~16'o001000);
        check("dati_rdata", core_bus.rdata, 16'o012737);
        check("dati_err", 16'(err_done), 16'd0);

        bus_cycle(2'b10, 16'o177567, 16'o000101);
        check("datob_addr_wtbt", 16'(ph_addr_wtbt), 16'd0);
        check("datob_data_wtbt", 16'(ph_data_wtbt), 16'd0);
        check("datob_dout", 16'(dout_seen), 16'd1);
        check("datob_ad", ph_data_ad, ~16'o000101);
        check("datob_written", wr_data, 16'o000101);

        bus_cycle(2'b01, 16'o001002, 16'o123456);
        check("dato_addr_wtbt", 16'(ph_addr_wtbt), 16'd0);
        check("dato_data_wtbt", 16'(ph_data_wtbt), 16'd1);
        check("dato_ad", ph_data_ad, ~16'o123456);

        bus_cycle(2'b11, 16'h0000, 16'h0000);
        check("iak_no_sync", 16'(sync_seen), 16'd0);
        check("iak_iako", 16'(iako_seen), 16'd1);
        check("iak_din_first", 16'(din_at), 16'd1);
        check("iak_vector", core_bus.rdata, 16'o000064);

        bus_cycle(2'b00, 16'o160000, 16'h0000);
        check("tmo_err", 16'(err_done), 16'd1);
        check("tmo_len", 16'(done_at - din_at), 16'(TMO));
        check("tmo_strobes", 16'(strobes_done), 16'hf);
        check("tmo_rdata_kept", core_bus.rdata, 16'o000064);

        pin_dmr_n = 1'b0; pin_rfrq_n = 1'b0;
        core_bus.req = 1'b1; core_bus.op = 2'b00; core_bus.addr = 16'o001000;
        n = 0; t_dmgo = -1; t_sack_rel = -1; t_dref = -1; t_sync = -1; dref_len = 0;
        dma_drive = 1'b0; done_seen = 1'b0;
        while (!done_seen && n < 300) begin
            @(posedge pin_clk); #1; n = n + 1;
            if (!pin_dmgo_n && t_dmgo < 0) begin
                t_dmgo = n; pin_sack_n = 1'b0; pin_dmr_n = 1'b1;
            end else if (!pin_sack_n) begin
                if (pin_ad_n != 16'hffff || !pin_sync_n || !pin_dref_n || !pin_dmgo_n) dma_drive = 1'b1;
                if (n == t_dmgo + 6) begin pin_sack_n = 1'b1; t_sack_rel = n; end
            end
            if (!pin_dref_n) begin
                dref_len = dref_len + 1;
                if (t_dref < 0) begin t_dref = n; pin_rfrq_n = 1'b1; end
            end
            if (!pin_sync_n && t_sync < 0) t_sync = n;
            if (core_bus.done) done_seen = 1'b1;
        end
        core_bus.req = 1'b0;
        check("prio_done", 16'(done_seen), 16'd1);
        check("prio_dmgo_first", 16'(t_dmgo), 16'd1);
        check("prio_dma_quiet", 16'(dma_drive), 16'd0);
        check("prio_ref_after_sack", 16'(t_dref > t_sack_rel && t_sack_rel > 0), 16'd1);
        check("prio_ref_width", 16'(dref_len), 16'(REF));
        check("prio_core_last", 16'(t_sync > t_dref + REF - 1 && t_dref > 0), 16'd1);
        check("prio_rdata", core_bus.rdata, 16'o012737);

        core_bus.req = 1'b1; core_bus.op = 2'b00; core_bus.addr = 16'o160000;
        n = 0;
        while (pin_din_n && n < 20) begin @(posedge pin_clk); #1; n = n + 1; end
        check("mid_din_low", 16'(pin_din_n), 16'd0);
        pin_rst = 1'b1; pin_bsel_n = 2'b10;
        @(posedge pin_clk); #1;
        check("mid_strobes_off", 16'({pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n}), 16'hf);
        check("mid_init_low", 16'(pin_init_n), 16'd0);
        pin_rst = 1'b0; core_bus.req = 1'b0;
        any_done = 1'b0; got_start = 1'b0; n = 0;
        while (!got_start && n < INI + 8) begin
            @(posedge pin_clk); #1; n = n + 1;
            if (core_bus.done) any_done = 1'b1;
            if (start) got_start = 1'b1;
        end
        check("mid_no_done", 16'(any_done), 16'd0);
        check("restart_seen", 16'(got_start), 16'd1);
        check("restart_mode", 16'(start_mode), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
